// File: rtl/byte_dual_port_ram.sv
// byte_dual_port_ram
// Dual-port byte-wide data RAM serving the data-memory controller's word
// sequence as two byte lanes (A, B) per cycle.
// Optional feature macro: BYTE_RAM_INIT_CLEAR_EN (post-reset clear sweep).
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   en           access enable (read or write)
//   we           write enable, effective only with en
//   addr_a/b     32-bit byte address per lane
//   data_a/b     write byte per lane
//   recv_data_a/b combinational read byte per lane (0 when not serviced)
//   busy         clear sweep in progress, accesses ignored
//   collision    one-cycle pulse after both lanes wrote the same byte
//   oor_err      sticky out-of-range access flag, cleared only by rst
module byte_dual_port_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr_a,
    input  logic [7:0]  data_a,
    input  logic [31:0] addr_b,
    input  logic [7:0]  data_b,
    output logic [7:0]  recv_data_a,
    output logic [7:0]  recv_data_b,
    output logic        busy,
    output logic        collision,
    output logic        oor_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] idx_a;
    logic [AW-1:0] idx_b;
    logic          oor_a_c;
    logic          oor_b_c;
    logic          active_c;
    logic          wr_a_c;
    logic          wr_b_c;
    logic          coll_c;

    // Lane decode: an address is out of range when any bit above the index is set
    assign idx_a    = addr_a[AW-1:0];
    assign idx_b    = addr_b[AW-1:0];
    assign oor_a_c  = en && (addr_a[31:AW] != '0);
    assign oor_b_c  = en && (addr_b[31:AW] != '0);
    assign active_c = en && !busy;
    assign wr_a_c   = active_c && we && !oor_a_c;
    assign wr_b_c   = active_c && we && !oor_b_c;
    assign coll_c   = wr_a_c && wr_b_c && (idx_a == idx_b);

`ifdef BYTE_RAM_INIT_CLEAR_EN
    // Sweep counter addresses byte pairs, so it needs one bit less than the index
    localparam int unsigned CW = AW - 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] clr_cnt_q;
    logic [CW-1:0] clr_cnt_d;
    logic          busy_d;

    // Clear FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy      <= busy_d;
        end
    end

    // Clear FSM next state: leave CLEAR on the edge that zeroes the last pair
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CW'(1);
                if (clr_cnt_q == CW'(DEPTH / 2 - 1)) begin
                    state_d   = S_READY;
                    clr_cnt_d = '0;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // Storage: sweep writes zero pairs, otherwise lane A then lane B (B wins on collision)
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[{clr_cnt_q, 1'b0}] <= 8'h00;
            mem[{clr_cnt_q, 1'b1}] <= 8'h00;
        end else begin
            if (wr_a_c) begin
                mem[idx_a] <= data_a;
            end
            if (wr_b_c) begin
                mem[idx_b] <= data_b;
            end
        end
    end
`else
    assign busy = 1'b0;

    // Storage: lane A then lane B, so lane B wins on a same-byte collision
    always_ff @(posedge clk) begin
        if (wr_a_c) begin
            mem[idx_a] <= data_a;
        end
        if (wr_b_c) begin
            mem[idx_b] <= data_b;
        end
    end
`endif

    // Status flags: collision pulse and sticky out-of-range error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= 1'b0;
            oor_err   <= 1'b0;
        end else begin
            collision <= coll_c;
            if (active_c && (oor_a_c || oor_b_c)) begin
                oor_err <= 1'b1;
            end
        end
    end

    // Asynchronous read, gated to zero when the lane is not serviced
    assign recv_data_a = (active_c && !oor_a_c) ? mem[idx_a] : 8'h00;
    assign recv_data_b = (active_c && !oor_b_c) ? mem[idx_b] : 8'h00;

endmodule

// File: tb/tb_byte_dual_port_ram.sv
// Self-checking bench for byte_dual_port_ram (DEPTH=1024), directed steps plus
// randomized traffic compared against an array-based reference model.
module tb_byte_dual_port_ram;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [31:0] addr_a;
    logic [7:0]  data_a;
    logic [31:0] addr_b;
    logic [7:0]  data_b;
    logic [7:0]  recv_data_a;
    logic [7:0]  recv_data_b;
    logic        busy;
    logic        collision;
    logic        oor_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte array, known-byte flags and expected flag values
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];
    bit         m_busy;
    bit         m_coll;
    bit         m_oor;

    byte_dual_port_ram #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .we          (we),
        .addr_a      (addr_a),
        .data_a      (data_a),
        .addr_b      (addr_b),
        .data_b      (data_b),
        .recv_data_a (recv_data_a),
        .recv_data_b (recv_data_b),
        .busy        (busy),
        .collision   (collision),
        .oor_err     (oor_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected read byte for one lane; unknown bytes are skipped
    task automatic check_lane(input string tag, input logic [31:0] addr, input logic [7:0] obs);
        if (!en || m_busy || addr >= 32'(DEPTH)) begin
            chk(tag, 32'(obs), 32'h0);
        end else if (m_known[addr[9:0]]) begin
            chk(tag, 32'(obs), 32'(m_mem[addr[9:0]]));
        end
    endtask

    // Advance the model by one edge using the currently driven inputs
    task automatic tick();
        bit ia;
        bit ib;
        ia = (addr_a < 32'(DEPTH));
        ib = (addr_b < 32'(DEPTH));
        m_coll = 1'b0;
        if (en && !m_busy) begin
            if (!ia || !ib) m_oor = 1'b1;
            m_coll = we && ia && ib && (addr_a == addr_b);
            if (we && ia) begin
                m_mem[addr_a[9:0]]   = data_a;
                m_known[addr_a[9:0]] = 1'b1;
            end
            if (we && ib) begin
                m_mem[addr_b[9:0]]   = data_b;
                m_known[addr_b[9:0]] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One access cycle: check reads before the edge, flags after it
    task automatic step(input string tag);
        #1;
        check_lane({tag, "_rd_a"}, addr_a, recv_data_a);
        check_lane({tag, "_rd_b"}, addr_b, recv_data_b);
        tick();
        chk({tag, "_collision"}, 32'(collision), 32'(m_coll));
        chk({tag, "_oor_err"}, 32'(oor_err), 32'(m_oor));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
    endtask

    task automatic drive(input bit e, input bit w, input logic [31:0] aa, input logic [7:0] da,
                         input logic [31:0] ab, input logic [7:0] db);
        en = e; we = w; addr_a = aa; data_a = da; addr_b = ab; data_b = db;
    endtask

    // Assert reset, check immediate async values, release away from the edge
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        m_coll = 1'b0;
        m_oor  = 1'b0;
`ifdef BYTE_RAM_INIT_CLEAR_EN
        m_busy = 1'b1;
`else
        m_busy = 1'b0;
`endif
        chk("rst_collision", 32'(collision), 32'h0);
        chk("rst_oor_err", 32'(oor_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'(m_busy));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef BYTE_RAM_INIT_CLEAR_EN
    // Count busy cycles after release while hammering accesses that must be ignored
    task automatic sweep(input int stop_at, output int cnt);
        drive(1'b1, 1'b1, 32'h400, 8'hFF, 32'h10, 8'hEE);
        #1;
        chk("sweep_rd_a", 32'(recv_data_a), 32'h0);
        chk("sweep_rd_b", 32'(recv_data_b), 32'h0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000 && (stop_at == 0 || cnt < stop_at)) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        if (stop_at == 0) begin
            drive(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 8'h0);
            chk("sweep_len", 32'(cnt), 32'(DEPTH / 2));
            chk("sweep_oor_err", 32'(oor_err), 32'h0);
            chk("sweep_collision", 32'(collision), 32'h0);
            m_busy = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_mem[i]   = 8'h00;
                m_known[i] = 1'b1;
            end
        end
    endtask
`endif

    function automatic logic [31:0] rand_addr(input bit allow_oor);
        if (allow_oor && $urandom_range(0, 7) == 0)
            return 32'(DEPTH) + 32'($urandom_range(0, 4095)) + ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0);
        return 32'($urandom_range(0, 31));
    endfunction

    task automatic random_phase(input int n, input bit allow_oor);
        for (int k = 0; k < n; k++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  rand_addr(allow_oor), 8'($urandom), rand_addr(allow_oor), 8'($urandom));
            step("rand");
        end
    endtask

    initial begin
        logic [31:0] word;
        int          cnt;

        for (int i = 0; i < int'(DEPTH); i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
        m_busy = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 8'h0);

        reset_pulse();
`ifdef BYTE_RAM_INIT_CLEAR_EN
        sweep(0, cnt);
        drive(1'b1, 1'b0, 32'h3FF, 8'h0, 32'h000, 8'h0);
        step("post_sweep");
`endif

        // Word write of 0xA1B2C3D4 at 0x10 as two lane-pair cycles, then read back
        drive(1'b1, 1'b1, 32'h10, 8'hD4, 32'h11, 8'hC3);
        step("wr_word0");
        drive(1'b1, 1'b1, 32'h12, 8'hB2, 32'h13, 8'hA1);
        step("wr_word1");
        drive(1'b1, 1'b0, 32'h10, 8'h0, 32'h11, 8'h0);
        #1;
        word[7:0]  = recv_data_a;
        word[15:8] = recv_data_b;
        step("rd_word0");
        drive(1'b1, 1'b0, 32'h12, 8'h0, 32'h13, 8'h0);
        #1;
        word[23:16] = recv_data_a;
        word[31:24] = recv_data_b;
        step("rd_word1");
        chk("word_read", word, 32'hA1B2C3D4);

        // Same-byte write on both lanes: lane B wins, one-cycle collision pulse
        drive(1'b1, 1'b1, 32'h20, 8'h11, 32'h20, 8'h22);
        step("coll_wr");
        chk("coll_pulse", 32'(collision), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 8'h0);
        step("coll_idle");
        drive(1'b1, 1'b0, 32'h20, 8'h0, 32'h21, 8'h0);
        #1;
        chk("coll_byte", 32'(recv_data_a), 32'h22);
        step("coll_rd");

        // Read-during-write on the same byte returns the old value before the edge
        drive(1'b1, 1'b1, 32'h20, 8'h5C, 32'h3FF, 8'h01);
        #1;
        chk("rdw_old", 32'(recv_data_a), 32'h22);
        step("rdw");

        random_phase(200, 1'b0);

        // Out-of-range lane A: dropped, no wrap to byte 0, sticky error
        drive(1'b1, 1'b1, 32'h000, 8'h3C, 32'h006, 8'h00);
        step("oor_pre");
        drive(1'b1, 1'b1, 32'h400, 8'h99, 32'h005, 8'h5A);
        #1;
        chk("oor_rd_a_zero", 32'(recv_data_a), 32'h0);
        step("oor_wr");
        chk("oor_set", 32'(oor_err), 32'h1);
        drive(1'b1, 1'b0, 32'h000, 8'h0, 32'h005, 8'h0);
        #1;
        chk("oor_nowrap", 32'(recv_data_a), 32'h3C);
        chk("oor_lane_b", 32'(recv_data_b), 32'h5A);
        step("oor_rd");
        drive(1'b0, 1'b0, 32'h0, 8'h0, 32'h0, 8'h0);
        step("oor_sticky");

        random_phase(150, 1'b1);

`ifdef BYTE_RAM_INIT_CLEAR_EN
        // Reset 200 cycles into the sweep restarts the full sweep
        reset_pulse();
        sweep(200, cnt);
        chk("mid_sweep_busy", 32'(busy), 32'h1);
        reset_pulse();
        sweep(0, cnt);
        drive(1'b1, 1'b0, 32'h3FF, 8'h0, 32'h000, 8'h0);
        step("post_resweep");
        random_phase(60, 1'b1);
`else
        // Contents survive reset when no sweep is built in
        drive(1'b1, 1'b1, 32'h30, 8'h77, 32'h31, 8'h78);
        step("keep_wr");
        reset_pulse();
        drive(1'b1, 1'b0, 32'h30, 8'h0, 32'h31, 8'h0);
        #1;
        chk("keep_byte", 32'(recv_data_a), 32'h77);
        step("keep_rd");
        random_phase(60, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
